hex_7seg_decoder: RTL and testbench



---
 rtl/hex_7seg_decoder.sv | 72 +++++++
 tb/tb_hex_7seg_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_7seg_decoder.sv
// Registered hex-to-seven-segment decoder, one digit, 1-cycle latency.
// Define HEX7SEG_ACTIVE_LOW_EN for active-low (common-anode) segment drive.
module hex_7seg_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic       o_e,
  output logic       o_f,
  output logic       o_g
);

`ifdef HEX7SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL_MASK = 7'b1111111;
`else
  localparam logic [6:0] POL_MASK = 7'b0000000;
`endif

  // Active-high glyph pattern {a,b,c,d,e,f,g} for one hex digit.
  function automatic logic [6:0] decode_glyph(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      4'hF:    seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [6:0] seg_s;
  logic [6:0] seg_r;

  // Decode then apply display polarity; the XOR mask also defines blank.
  always_comb begin
    seg_s = decode_glyph(in) ^ POL_MASK;
  end

  // Output register; reset forces blank so no stale glyph survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= POL_MASK;
    end else begin
      seg_r <= seg_s;
    end
  end

  assign o_a = seg_r[6];
  assign o_b = seg_r[5];
  assign o_c = seg_r[4];
  assign o_d = seg_r[3];
  assign o_e = seg_r[2];
  assign o_f = seg_r[1];
  assign o_g = seg_r[0];

endmodule

// File: tb/tb_hex_7seg_decoder.sv
// Scoreboard bench for hex_7seg_decoder: segment-name reference model,
// queued expectations, and a monitor that checks one cycle after each input.
module tb_hex_7seg_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_s;
  logic       o_a, o_b, o_c, o_d, o_e, o_f, o_g;
  logic [6:0] act_s;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  hex_7seg_decoder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_s),
    .o_a  (o_a),
    .o_b  (o_b),
    .o_c  (o_c),
    .o_d  (o_d),
    .o_e  (o_e),
    .o_f  (o_f),
    .o_g  (o_g)
  );

  assign act_s = {o_a, o_b, o_c, o_d, o_e, o_f, o_g};

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HEX7SEG_ACTIVE_LOW_EN
  localparam bit ACTIVE_LOW = 1'b1;
`else
  localparam bit ACTIVE_LOW = 1'b0;
`endif

  // Which segments are lit for each hex glyph, by segment letter.
  string glyph_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] blank_val();
    return ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  endfunction

  function automatic logic [6:0] model(input int digit);
    logic [6:0] lit;
    string s;
    int idx;
    lit = 7'b0000000;
    s = glyph_segs[digit];
    for (int k = 0; k < s.len(); k++) begin
      idx = 6 - int'(s[k] - "a");
      lit[idx] = 1'b1;
    end
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v);
    @(negedge clk);
    in_s = v[3:0];
    exp_q.push_back(model(v));
  endtask

  // Monitor: one output per cycle while out of reset and something is owed.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pipe", act_s, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_s  = 4'h8;
    #1;
    check("reset_initial", act_s, blank_val());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", act_s, blank_val());
    end

    // Release between edges with in=8 still applied.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(8));

    for (int v = 0; v < 16; v++) drive(v);
    drive(1);
    drive(8);
    drive(1);
    for (int i = 0; i < 10; i++) drive(5);
    for (int i = 0; i < 40; i++) drive(int'($urandom_range(0, 15)));

    // Mid-stream asynchronous reset after showing A.
    drive(10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", act_s, blank_val());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_s = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("async_reset_hold", act_s, blank_val());
    end
    @(negedge clk);
    in_s = 4'hA;
    rst_n = 1'b1;
    exp_q.push_back(model(10));

    for (int i = 0; i < 20; i++) drive(int'($urandom_range(0, 15)));

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
